// File: rtl/core_pkg.sv
// Shared definitions for the pipeline sequencer: forward-select codes,
// the zero register index and the shadow-stage record.
package core_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } shadow_stage_t;

    // A stage supplies source r only if it really writes a non-zero rd equal
    // to r, and the ID instruction actually reads that source.
    function automatic logic src_match(input shadow_stage_t s,
                                       input logic [4:0]    r,
                                       input logic          use_r);
        return s.valid & s.reg_write & (s.rd == r) & (r != REG_X0) & use_r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard detection, stall/flush control and forward-select generation for
// the 5-stage RV32I pipeline. A shadow copy of rd/write/load info for EX,
// MEM and WB is compared against the ID sources each cycle.
import core_pkg::*;

module hazard_control_unit #(
    parameter bit FORWARDING_EN = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             ex_redirect_i,
    output logic             pc_enable_o,
    output logic             if_id_enable_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    shadow_stage_t ex_q, mem_q, wb_q;
    logic [2:0]    match_a, match_b;   // bit 0 = EX, 1 = MEM, 2 = WB
    logic          hazard_a, hazard_b;
    logic          stall, advance;
    logic [1:0]    sel_a_next, sel_b_next;

    // Per-source matches and the stall decision. With forwarding, only a
    // load in EX or a WB-only producer (register file is not write-through)
    // needs a stall; without it, any in-flight producer does.
    always_comb begin
        match_a[0] = src_match(ex_q,  id_rs1_i, id_use_rs1_i);
        match_a[1] = src_match(mem_q, id_rs1_i, id_use_rs1_i);
        match_a[2] = src_match(wb_q,  id_rs1_i, id_use_rs1_i);
        match_b[0] = src_match(ex_q,  id_rs2_i, id_use_rs2_i);
        match_b[1] = src_match(mem_q, id_rs2_i, id_use_rs2_i);
        match_b[2] = src_match(wb_q,  id_rs2_i, id_use_rs2_i);
        if (FORWARDING_EN) begin
            hazard_a = (match_a[0] & ex_q.mem_read) | (match_a[2] & ~match_a[0] & ~match_a[1]);
            hazard_b = (match_b[0] & ex_q.mem_read) | (match_b[2] & ~match_b[0] & ~match_b[1]);
        end else begin
            hazard_a = |match_a;
            hazard_b = |match_b;
        end
        stall   = id_valid_i & (hazard_a | hazard_b);
        advance = ~stall & ~ex_redirect_i;
    end

    // Pipeline control: a redirect overrides a stall and flushes IF/ID.
    always_comb begin
        pc_enable_o    = ex_redirect_i | ~stall;
        if_id_enable_o = ex_redirect_i | ~stall;
        if_id_flush_o  = ex_redirect_i;
        id_ex_bubble_o = ex_redirect_i | stall;
    end

    // Forward select for the instruction about to enter EX, youngest first.
    always_comb begin
        sel_a_next = FWD_IDEX;
        sel_b_next = FWD_IDEX;
        if (FORWARDING_EN) begin
            if (match_a[0] & ~ex_q.mem_read) sel_a_next = FWD_EXMEM;
            else if (match_a[1])             sel_a_next = FWD_MEMWB;
            if (match_b[0] & ~ex_q.mem_read) sel_b_next = FWD_EXMEM;
            else if (match_b[1])             sel_b_next = FWD_MEMWB;
        end
    end

    // Shadow pipeline: shift every cycle, inserting a bubble into EX when
    // ID is held or squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= '{valid:     id_valid_i & advance,
                       rd:        id_rd_i,
                       reg_write: id_reg_write_i,
                       mem_read:  id_mem_read_i};
        end
    end

    // Registered forward selects; cleared whenever ID does not advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_sel_o <= FWD_IDEX;
            fwd_b_sel_o <= FWD_IDEX;
        end else begin
            fwd_a_sel_o <= advance ? sel_a_next : FWD_IDEX;
            fwd_b_sel_o <= advance ? sel_b_next : FWD_IDEX;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall & ~ex_redirect_i),
        .count (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ex_redirect_i),
        .count (flush_count_o)
    );

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Detects RAW and load-use hazards against the instruction in ID, and drives PC/IF-ID enables, ID/EX bubble insertion and IF/ID flush.
- Produces the registered forwarding selects for EX, and saturating stall/flush performance counters.

Parameters:
- FORWARDING_EN, 1: 1 = forward from EX/MEM and MEM/WB; 0 = stall on every in-flight RAW.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction (not a bubble)
- id_rs1_i  in  5  ID source register 1
- id_rs2_i  in  5  ID source register 2
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- id_rd_i  in  5  ID destination register
- id_reg_write_i  in  1  ID instruction writes rd
- id_mem_read_i  in  1  ID instruction is a load
- ex_redirect_i  in  1  taken branch/JAL/JALR resolved in EX this cycle
- pc_enable_o  out  1  PC register load enable
- if_id_enable_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID is loaded with a bubble
- id_ex_bubble_o  out  1  ID/EX control fields forced to 0
- fwd_a_sel_o  out  2  EX operand A source: 00 = ID/EX, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data
- fwd_b_sel_o  out  2  EX operand B source, same encoding
- stall_cycles_o  out  CNT_W  count of stall cycles
- flush_count_o  out  CNT_W  count of redirect flushes

Behaviour:
- Shadow stages EX, MEM, WB: each holds {valid, rd, reg_write, mem_read}.
- Every clock: WB <= MEM; MEM <= EX.
- EX <= ID fields with valid = id_valid_i & ~stall & ~ex_redirect_i; otherwise EX.valid <= 0.
- Source match: a stage matches source r when stage.valid & stage.reg_write & stage.rd == r & r != 0 & the corresponding use bit is set. x0 never matches.
- Stall condition, FORWARDING_EN=1, combinational. Any of:
  - EX match with EX.mem_read (load-use);
  - WB match, with no younger EX or MEM match on that source. The register file is not write-through, so the value read in ID is stale.
- Stall condition, FORWARDING_EN=0: any EX, MEM or WB match.
- Stall is qualified by id_valid_i.
- Outputs during a stall (and no redirect):
  - pc_enable_o = 0
  - if_id_enable_o = 0
  - id_ex_bubble_o = 1
  - if_id_flush_o = 0
- Redirect: ex_redirect_i = 1 overrides stall.
  - pc_enable_o = 1, if_id_enable_o = 1, if_id_flush_o = 1, id_ex_bubble_o = 1.
  - Penalty is 2 cycles; the block holds no redirect state.
- Forward selects: registered, and updated only when ID advances (no stall, no redirect). Otherwise they load 00.
  - Priority is youngest first: EX match (non-load) -> 10; else MEM match -> 01; else 00.
  - With FORWARDING_EN=0 they are always 00.
- Latency: hazard detection is combinational, same cycle. Forward selects take effect 1 cycle later, when the consumer is in EX.
- Counters:
  - stall_cycles_o increments in each cycle where stall = 1 and ex_redirect_i = 0.
  - flush_count_o increments in each cycle where ex_redirect_i = 1.
  - Both saturate at all-ones with no wrap.
- Reset (asynchronous, any time, including mid-stall):
  - all shadow valid = 0, forward selects = 00, counters = 0;
  - combinational outputs then read pc_enable_o = 1, if_id_enable_o = 1, if_id_flush_o = ex_redirect_i, id_ex_bubble_o = ex_redirect_i;
  - no stall is carried over after reset is released.

Decomposition:
- Shared package core_pkg holds:
  - FWD_IDEX = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01;
  - REG_X0 = 5'd0;
  - the shadow-stage struct {valid, rd, reg_write, mem_read}.
- One natural sub-module: sat_counter (parameterised width, increment enable, async reset), instantiated twice.

Test Plan:
- Load-use, FORWARDING_EN=1: lw x5 enters EX; ID add x6,x5,x7 -> exactly 1 stall cycle (pc_enable_o = 0, id_ex_bubble_o = 1); next cycle fwd_a_sel_o = 01; stall_cycles_o = 1.
- ALU chain: addi x1,x0,3 in EX; ID add x2,x1,x1 -> no stall; next cycle fwd_a_sel_o = fwd_b_sel_o = 10.
- x0 and precedence: writer rd = x0 followed by a reader of x0 -> no stall, selects 00. Writers to x3 in both EX and MEM -> select 10 (youngest wins).
- FORWARDING_EN=0: addi x1 followed by add x2,x1,x0 -> exactly 3 stall cycles, then advance; selects always 00.
- Redirect during load-use: ex_redirect_i = 1 in the same cycle as a load-use match -> if_id_flush_o = 1, pc_enable_o = 1, stall_cycles_o unchanged, flush_count_o += 1.
- Saturation and reset: with CNT_W=4, 20 redirects -> flush_count_o = 15. Assert reset mid-stall -> the stall drops immediately, counters read 0, selects read 00.
